// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the default operand width.
package alu_pkg;
    localparam int WIDTH_DEF = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
endpackage

// File: rtl/booth_div_datapath_if.sv
// Control-strobe / status / result bundle between the ALU controller and the
// Booth multiply / non-restoring divide datapath.
interface booth_div_if #(parameter int WIDTH = alu_pkg::WIDTH_DEF);
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic               booth_load, booth_shift_en, booth_add_en, booth_sub_en, booth_count_en;
    logic               div_load, div_shift_en, div_add_en, div_sub_en, div_final_add, div_count_en;
    logic               booth_Q0, booth_Qm1, booth_done, div_done, div_R_sign;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    modport master (
        output operand_a, operand_b,
        output booth_load, booth_shift_en, booth_add_en, booth_sub_en, booth_count_en,
        output div_load, div_shift_en, div_add_en, div_sub_en, div_final_add, div_count_en,
        input  booth_Q0, booth_Qm1, booth_done, div_done, div_R_sign,
        input  product, quotient, remainder
    );

    modport slave (
        input  operand_a, operand_b,
        input  booth_load, booth_shift_en, booth_add_en, booth_sub_en, booth_count_en,
        input  div_load, div_shift_en, div_add_en, div_sub_en, div_final_add, div_count_en,
        output booth_Q0, booth_Qm1, booth_done, div_done, div_R_sign,
        output product, quotient, remainder
    );
endinterface

// File: rtl/booth_div_datapath_nr_div_path.sv
// Unsigned non-restoring divider registers (R, Q, D, count) and their flags.
// R carries one extra bit so its MSB is the partial-remainder sign.
module nr_div_path #(
    parameter int WIDTH = alu_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic             add_en_i,
    input  logic             sub_en_i,
    input  logic             final_add_i,
    input  logic             count_en_i,
    output logic             done_o,
    output logic             r_sign_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   r_q, r_d, d_q, d_d, r_sh, r_op;
    logic [WIDTH-1:0] q_q, q_d, q_sh;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Next state: shift, then add/sub (quotient bit from the new sign), then final correction.
    always_comb begin
        r_sh  = r_q;
        q_sh  = q_q;
        if (shift_en_i) begin
            r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
            q_sh = q_q << 1;
        end
        r_op = r_sh;
        if (add_en_i && !sub_en_i)      r_op = r_sh + d_q;
        else if (sub_en_i && !add_en_i) r_op = r_sh - d_q;
        if (add_en_i ^ sub_en_i)        q_sh[0] = ~r_op[WIDTH];
        if (final_add_i && r_op[WIDTH]) r_op = r_op + d_q;

        r_d   = r_op;
        q_d   = q_sh;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (count_en_i && cnt_q != CW'(WIDTH)) cnt_d = cnt_q + 1'b1;

        if (load_i) begin
            r_d   = '0;
            q_d   = operand_a_i;
            d_d   = {1'b0, operand_b_i};
            cnt_d = '0;
        end
    end

    // Divider state registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == CW'(WIDTH));
    assign r_sign_o    = r_q[WIDTH];
    assign quotient_o  = q_q;
    assign remainder_o = r_q[WIDTH-1:0];
endmodule

// File: rtl/booth_div_datapath.sv
// Booth signed multiplier registers plus the non-restoring divider sub-block.
// A and M carry one extra bit so a multiplicand of -2^(WIDTH-1) still works.
module booth_div_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    booth_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   a_q, a_d, m_q, m_d, sum;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;

    // Next state: add/sub first, then optionally arithmetic-shift the result.
    always_comb begin
        sum = a_q;
        if (bus.booth_add_en && !bus.booth_sub_en)      sum = a_q + m_q;
        else if (bus.booth_sub_en && !bus.booth_add_en) sum = a_q - m_q;

        a_d    = sum;
        q_d    = q_q;
        qm1_d  = qm1_q;
        m_d    = m_q;
        bcnt_d = bcnt_q;
        if (bus.booth_shift_en) begin
            a_d   = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
        end
        if (bus.booth_count_en && bcnt_q != CW'(WIDTH)) bcnt_d = bcnt_q + 1'b1;

        if (bus.booth_load) begin
            a_d    = '0;
            q_d    = bus.operand_b;
            qm1_d  = 1'b0;
            m_d    = {bus.operand_a[WIDTH-1], bus.operand_a};
            bcnt_d = '0;
        end
    end

    // Booth state registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            bcnt_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            qm1_q  <= qm1_d;
            m_q    <= m_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign bus.booth_Q0   = q_q[0];
    assign bus.booth_Qm1  = qm1_q;
    assign bus.booth_done = (bcnt_q == CW'(WIDTH - 1));
    assign bus.product    = {a_q[WIDTH-1:0], q_q};

    nr_div_path #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .operand_a_i (bus.operand_a),
        .operand_b_i (bus.operand_b),
        .load_i      (bus.div_load),
        .shift_en_i  (bus.div_shift_en),
        .add_en_i    (bus.div_add_en),
        .sub_en_i    (bus.div_sub_en),
        .final_add_i (bus.div_final_add),
        .count_en_i  (bus.div_count_en),
        .done_o      (bus.div_done),
        .r_sign_o    (bus.div_R_sign),
        .quotient_o  (bus.quotient),
        .remainder_o (bus.remainder)
    );
endmodule

// File: tb/tb_booth_div_datapath.sv
// Self-checking bench: acts as the ALU controller, issuing Booth and divider
// strobe sequences, and compares results against plain arithmetic.
module tb_booth_div_datapath;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    booth_div_if #(.WIDTH(W)) bus ();

    booth_div_datapath #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_div;
        logic [7:0]  a, b;
        logic [15:0] exp_p;
        logic [7:0]  exp_q, exp_r;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.booth_load = 0; bus.booth_shift_en = 0; bus.booth_add_en = 0;
        bus.booth_sub_en = 0; bus.booth_count_en = 0;
        bus.div_load = 0; bus.div_shift_en = 0; bus.div_add_en = 0;
        bus.div_sub_en = 0; bus.div_final_add = 0; bus.div_count_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic booth_ld(input logic [7:0] a, input logic [7:0] b);
        bus.operand_a = a; bus.operand_b = b; bus.booth_load = 1;
        tick();
    endtask

    // One Booth iteration: recode {Q0,Qm1}, op + shift + count in one cycle.
    task automatic booth_iter(input int i, input bit chk_done);
        bus.booth_sub_en   = bus.booth_Q0 & ~bus.booth_Qm1;
        bus.booth_add_en   = ~bus.booth_Q0 & bus.booth_Qm1;
        bus.booth_shift_en = 1; bus.booth_count_en = 1;
        if (chk_done) chk($sformatf("booth_done it%0d", i), bus.booth_done, (i == W - 1));
        tick();
    endtask

    task automatic div_ld(input logic [7:0] a, input logic [7:0] b);
        bus.operand_a = a; bus.operand_b = b; bus.div_load = 1;
        tick();
    endtask

    // Non-restoring iterations: the pre-shift sign picks add or subtract.
    task automatic div_iters(input bit chk_done);
        logic sgn;
        for (int i = 0; i < W; i++) begin
            sgn = bus.div_R_sign;
            bus.div_shift_en = 1; bus.div_count_en = 1;
            if (chk_done) chk($sformatf("div_done shift%0d", i), bus.div_done, 1'b0);
            tick();
            bus.div_add_en = sgn; bus.div_sub_en = ~sgn;
            if (chk_done) chk($sformatf("div_done op%0d", i), bus.div_done, (i == W - 1));
            tick();
        end
        bus.div_final_add = 1;
        tick();
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit chk_done);
        booth_ld(a, b);
        for (int i = 0; i < W; i++) booth_iter(i, chk_done);
    endtask

    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit chk_done);
        div_ld(a, b);
        div_iters(chk_done);
    endtask

    function automatic logic [15:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
        int pa, pb;
        pa = $signed(a);
        pb = $signed(b);
        return 16'(pa * pb);
    endfunction

    function automatic logic [15:0] div_ref(input logic [7:0] a, input logic [7:0] b);
        if (b == 0) return {8'hFF, a};
        return {8'(a / b), 8'(a % b)};
    endfunction

    initial begin
        vec_t vecs[$];
        logic [7:0]  ra, rb;
        logic [15:0] dr;

        idle();
        bus.operand_a = '0; bus.operand_b = '0;
        vecs.push_back('{0, 8'h07, 8'hFD, 16'hFFEB, 8'h00, 8'h00});
        vecs.push_back('{0, 8'h80, 8'h80, 16'h4000, 8'h00, 8'h00});
        vecs.push_back('{0, 8'h03, 8'h05, 16'h000F, 8'h00, 8'h00});
        vecs.push_back('{0, 8'h7F, 8'h80, 16'hC080, 8'h00, 8'h00});
        vecs.push_back('{0, 8'hFF, 8'hFF, 16'h0001, 8'h00, 8'h00});
        vecs.push_back('{1, 8'h64, 8'h07, 16'h0000, 8'h0E, 8'h02});
        vecs.push_back('{1, 8'hFF, 8'h10, 16'h0000, 8'h0F, 8'h0F});
        vecs.push_back('{1, 8'h5A, 8'h00, 16'h0000, 8'hFF, 8'h5A});
        vecs.push_back('{1, 8'h07, 8'h64, 16'h0000, 8'h00, 8'h07});
        vecs.push_back('{1, 8'hFF, 8'h01, 16'h0000, 8'hFF, 8'h00});

        // reset state
        #12;
        chk("rst product", bus.product, 16'h0);
        chk("rst quotient", bus.quotient, 8'h0);
        chk("rst remainder", bus.remainder, 8'h0);
        chk("rst flags", {bus.booth_Q0, bus.booth_Qm1, bus.booth_done, bus.div_done, bus.div_R_sign}, 5'b0);
        reset_n = 1'b1;
        tick();

        // table vectors; done-flag timing checked on the first mul and first div
        foreach (vecs[k]) begin
            if (vecs[k].is_div) begin
                run_div(vecs[k].a, vecs[k].b, k == 5);
                chk($sformatf("vec%0d quotient", k), bus.quotient, vecs[k].exp_q);
                chk($sformatf("vec%0d remainder", k), bus.remainder, vecs[k].exp_r);
            end else begin
                run_mul(vecs[k].a, vecs[k].b, k == 0);
                chk($sformatf("vec%0d product", k), bus.product, vecs[k].exp_p);
            end
        end

        // results hold with no strobes
        repeat (3) tick();
        chk("hold remainder", bus.remainder, 8'hFF & 8'h00);
        chk("hold product", bus.product, 16'h0001);

        // 0 x 0x55 with shifts only
        booth_ld(8'h00, 8'h55);
        for (int i = 0; i < W; i++) begin
            bus.booth_shift_en = 1; bus.booth_count_en = 1;
            tick();
        end
        chk("mul 0x55 shift-only", bus.product, 16'h0000);

        // async reset in the 4th Booth iteration
        booth_ld(8'h07, 8'hFD);
        for (int i = 0; i < 3; i++) booth_iter(i, 1'b0);
        bus.booth_sub_en = bus.booth_Q0 & ~bus.booth_Qm1;
        bus.booth_add_en = ~bus.booth_Q0 & bus.booth_Qm1;
        bus.booth_shift_en = 1; bus.booth_count_en = 1;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst product", bus.product, 16'h0);
        chk("midrst flags", {bus.booth_Q0, bus.booth_Qm1, bus.booth_done, bus.div_done, bus.div_R_sign}, 5'b0);
        chk("midrst quot/rem", {bus.quotient, bus.remainder}, 16'h0);
        idle();
        @(negedge clk) reset_n = 1'b1;
        tick();
        run_mul(8'h03, 8'h05, 1'b0);
        chk("post-rst 3x5", bus.product, 16'h000F);

        // load wins over add/shift in the same cycle
        bus.operand_a = 8'h12; bus.operand_b = 8'h34;
        bus.booth_load = 1; bus.booth_add_en = 1; bus.booth_shift_en = 1; bus.booth_count_en = 1;
        tick();
        chk("load prio product", bus.product, 16'h0034);
        chk("load prio Qm1/done", {bus.booth_Qm1, bus.booth_done}, 2'b00);
        for (int i = 0; i < W; i++) booth_iter(i, 1'b0);
        chk("load prio mul", bus.product, mul_ref(8'h12, 8'h34));

        // div_load in the middle of a Booth operation
        booth_ld(8'h07, 8'hFD);
        for (int i = 0; i < W; i++) begin
            if (i == 4) begin
                bus.operand_a = 8'h64; bus.operand_b = 8'h07; bus.div_load = 1;
            end
            booth_iter(i, 1'b0);
        end
        chk("cross product", bus.product, 16'hFFEB);
        div_iters(1'b0);
        chk("cross quotient", bus.quotient, 8'h0E);
        chk("cross remainder", bus.remainder, 8'h02);
        chk("cross product kept", bus.product, 16'hFFEB);

        // randomized against plain arithmetic
        for (int n = 0; n < 25; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n == 3) rb = 8'h00;
            run_mul(ra, rb, 1'b0);
            chk($sformatf("rnd mul %h*%h", ra, rb), bus.product, mul_ref(ra, rb));
            run_div(ra, rb, 1'b0);
            dr = div_ref(ra, rb);
            chk($sformatf("rnd div %h/%h", ra, rb), {bus.quotient, bus.remainder}, dr);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
